// File: rtl/result_bram_reader_pkg.sv
// Shared types and constants for the result BRAM reader.
// Widths follow the result BRAM port-B geometry.
package result_bram_pkg;

  localparam int BRAM_ADDR_W = 20;
  localparam int WORD_W      = 32;
  localparam int WORD_IDX_W  = 15;
  localparam int RD_LAT_MIN  = 1;
  localparam int RD_LAT_MAX  = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/result_bram_reader_if.sv
// Output word stream of the result BRAM reader.
// valid/ready handshake with a last-word marker.
interface result_bram_reader_if;
  import result_bram_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/result_bram_reader_rd_fifo.sv
// Synchronous FIFO with count and registered head word.
// The head register is refreshed from the next-cycle head slot.
module rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW-1:0]    rp_n;
  logic             pop;

  always_comb begin
    pop  = rd_en && count != '0;
    rp_n = rp + AW'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= wdata;
    end
  end

  // Head is the incoming word when the FIFO is empty after this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (wr_en) begin
        wp <= wp + 1'b1;
      end
      rp    <= rp_n;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (count == (AW+1)'(pop)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[rp_n];
      end
    end
  end

endmodule

// File: rtl/result_bram_reader.sv
// Sweeps a word range out of BRAM port B and streams it
// through a credit-limited output FIFO.
module result_bram_reader
  import result_bram_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORD_IDX_W-1:0]  base_word,
  input  logic [CNT_W-1:0]       word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   bram_web,
  output logic [BRAM_ADDR_W-1:0] bram_addrb,
  output logic                   bram_dinb,
  input  logic [WORD_W-1:0]      bram_doutb,
  result_bram_reader_if.master   out
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PAD = BRAM_ADDR_W - WORD_IDX_W;

  state_t                state;
  state_t                state_n;
  logic [WORD_IDX_W-1:0] addr;
  logic [WORD_IDX_W-1:0] last_addr;
  logic [CNT_W-1:0]      remaining;
  logic [RD_LAT-1:0]     vpipe;
  logic [RD_LAT-1:0]     lpipe;
  logic [CW-1:0]         occ;
  int                    inflight;
  logic                  credit;
  logic                  issue;
  logic                  fin;
  logic                  pop;
  logic                  drained;
  fifo_word_t            wr_word;
  fifo_word_t            rd_word;

  // Drained also covers the cycle in which the final word leaves.
  always_comb begin
    inflight = $countones(vpipe);
    credit   = (int'(occ) + inflight) < FIFO_DEPTH;
    issue    = state == RUN && remaining != '0 && credit;
    fin      = issue && remaining == CNT_W'(1);
    pop      = out.out_valid && out.out_ready;
    drained  = vpipe == '0 &&
               (occ == '0 || (occ == CW'(1) && pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A zero-length sweep spends one cycle in RUN so busy is seen.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = RUN;
      RUN: begin
        if (remaining == '0) begin
          state_n = DONE;
        end else if (fin) begin
          state_n = DRAIN;
        end
      end
      DRAIN: if (drained) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      last_addr <= '0;
      remaining <= '0;
      vpipe     <= '0;
      lpipe     <= '0;
    end else begin
      vpipe <= (vpipe << 1) | RD_LAT'(issue);
      lpipe <= (lpipe << 1) | RD_LAT'(fin);
      if (state == IDLE && start) begin
        addr      <= base_word;
        remaining <= word_count;
      end else if (issue) begin
        addr      <= addr + 1'b1;
        last_addr <= addr;
        remaining <= remaining - 1'b1;
      end
    end
  end

  always_comb begin
    busy       = state == RUN || state == DRAIN;
    done       = state == DONE;
    bram_web   = 1'b0;
    bram_dinb  = 1'b0;
    bram_addrb = {PAD'(0), issue ? addr : last_addr};
  end

  assign wr_word = '{last: lpipe[RD_LAT-1], data: bram_doutb};

  rd_fifo #(
    .WIDTH ($bits(fifo_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (vpipe[RD_LAT-1]),
    .wdata (wr_word),
    .rd_en (pop),
    .rdata (rd_word),
    .count (occ)
  );

  assign out.out_valid = occ != '0;
  assign out.out_data  = rd_word.data;
  assign out.out_last  = rd_word.last && out.out_valid;

endmodule

// File: tb/tb_result_bram_reader.sv
// Bench for result_bram_reader: RD_LAT 1/2/3 instances share
// stimulus; each is checked against a range/arithmetic model.
module tb_result_bram_reader;
  import result_bram_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [14:0] base_word = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic [31:0] salt = '0;

  logic [2:0] bsy, dn, web, dinb, ov, ol;
  logic [2:0][19:0] addrb;
  logic [2:0][31:0] od, dout;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_bram_reader_if if0();
  result_bram_reader_if if1();
  result_bram_reader_if if2();

  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  assign if2.out_ready = out_ready;
  assign ov = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign ol = {if2.out_last, if1.out_last, if0.out_last};
  assign od[0] = if0.out_data;
  assign od[1] = if1.out_data;
  assign od[2] = if2.out_data;

  result_bram_reader #(.RD_LAT(1), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_word(base_word), .word_count(word_count),
    .busy(bsy[0]), .done(dn[0]), .bram_web(web[0]),
    .bram_addrb(addrb[0]), .bram_dinb(dinb[0]),
    .bram_doutb(dout[0]), .out(if0)
  );

  result_bram_reader #(.RD_LAT(2), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_word(base_word), .word_count(word_count),
    .busy(bsy[1]), .done(dn[1]), .bram_web(web[1]),
    .bram_addrb(addrb[1]), .bram_dinb(dinb[1]),
    .bram_doutb(dout[1]), .out(if1)
  );

  result_bram_reader #(.RD_LAT(3), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_word(base_word), .word_count(word_count),
    .busy(bsy[2]), .done(dn[2]), .bram_web(web[2]),
    .bram_addrb(addrb[2]), .bram_dinb(dinb[2]),
    .bram_doutb(dout[2]), .out(if2)
  );

  function automatic logic [31:0] bram_word(
    input logic [14:0] idx, input logic [31:0] s);
    return (32'hA500_0000 + {17'b0, idx}) ^ s;
  endfunction

  // BRAM port B: data for an address appears RD_LAT cycles later.
  logic [14:0] ap [3][3];
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      ap[k][0] <= addrb[k][14:0];
      ap[k][1] <= ap[k][0];
      ap[k][2] <= ap[k][1];
    end
  end
  assign dout[0] = bram_word(ap[0][0], salt);
  assign dout[1] = bram_word(ap[1][1], salt);
  assign dout[2] = bram_word(ap[2][2], salt);

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  logic [32:0] rxq [3][$];
  int first_v [3];
  int last_x [3];
  int done_c [3];
  int ndone [3];
  logic moved [3];
  logic [2:0] p_ov = '0;
  logic [2:0] p_x = '0;
  logic [2:0][32:0] p_d;
  logic [2:0][19:0] p_a;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n) begin
        if (p_ov[k] && !p_x[k]) begin
          chk("hold_valid", ov[k], 1);
          chk("hold_data", {ol[k], od[k]}, p_d[k]);
        end
        if (ov[k] && first_v[k] < 0) first_v[k] = cyc;
        if (ov[k] && out_ready) begin
          rxq[k].push_back({ol[k], od[k]});
          last_x[k] = cyc;
        end
        if (dn[k]) begin
          ndone[k]++;
          done_c[k] = cyc;
          chk("busy_at_done", bsy[k], 0);
        end
        if (addrb[k] != p_a[k]) moved[k] = 1'b1;
      end
      p_ov[k] = ov[k];
      p_x[k] = ov[k] && out_ready;
      p_d[k] = {ol[k], od[k]};
      p_a[k] = addrb[k];
    end
  end

  function automatic logic rdy(input int mode, input int g);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (g % 4 == 0) || (g % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic clear_mon();
    for (int k = 0; k < 3; k++) begin
      rxq[k].delete();
      first_v[k] = -1;
      last_x[k] = -1;
      done_c[k] = -1;
      ndone[k] = 0;
      moved[k] = 1'b0;
    end
  endtask

  task automatic chk_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", bsy[k], 0);
      chk("rst_done", dn[k], 0);
      chk("rst_valid", ov[k], 0);
      chk("rst_last", ol[k], 0);
      chk("rst_addrb", addrb[k], 0);
      chk("rst_web", web[k], 0);
      chk("rst_dinb", dinb[k], 0);
    end
  endtask

  task automatic sweep(input logic [14:0] b, input int n,
                       input int mode, input int inj);
    int t0;
    int g;
    logic [14:0] idx;
    logic [32:0] e;
    clear_mon();
    @(posedge clk); #1;
    base_word = b;
    word_count = CNT_W'(n);
    start = 1'b1;
    out_ready = rdy(mode, 0);
    t0 = cyc;
    g = 0;
    while (g < 600 &&
           (ndone[0] == 0 || ndone[1] == 0 || ndone[2] == 0)) begin
      g++;
      @(posedge clk); #1;
      start = (g == inj);
      if (g == inj) begin
        base_word = ~b;
        word_count = CNT_W'(n + 5);
      end
      out_ready = rdy(mode, g);
      if (g == 1) begin
        for (int k = 0; k < 3; k++) chk("busy_after_start", bsy[k], 1);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("done_once", ndone[k], 1);
      chk("rx_count", rxq[k].size(), n);
      for (int i = 0; i < n && i < rxq[k].size(); i++) begin
        idx = b + 15'(i);
        e = {i == n - 1, bram_word(idx, salt)};
        chk("rx_word", rxq[k][i], e);
      end
      if (n == 0) begin
        chk("zero_done_cyc", done_c[k], t0 + 2);
        chk("zero_no_addr", moved[k], 0);
        chk("zero_no_valid", first_v[k], -1);
      end else begin
        chk("done_after_last", done_c[k], last_x[k] + 1);
        if (mode == 0) begin
          chk("first_valid_cyc", first_v[k], t0 + 3 + k);
          if (k < 2) chk("throughput", last_x[k] - first_v[k], n - 1);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [32:0] e;
    int g;
    int n;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    out_ready = 1'b1;

    sweep(15'h0010, 8, 0, 0);
    sweep(15'h0010, 8, 1, 0);
    sweep(15'h0020, 5, 0, 0);
    sweep(15'h7FFE, 4, 0, 0);
    sweep(15'h1234, 0, 0, 0);
    sweep(15'h0040, 10, 0, 3);

    // Reset in the middle of a 10-word sweep.
    clear_mon();
    @(posedge clk); #1;
    base_word = 15'h0200;
    word_count = CNT_W'(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (g < 100 && rxq[0].size() < 3) begin
      g++;
      @(posedge clk); #1;
    end
    chk("mid_rst_reach3", rxq[0].size() >= 3, 1);
    rst_n = 1'b0;
    #1;
    chk_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3 && i < rxq[0].size(); i++) begin
      e = {1'b0, bram_word(15'h0200 + 15'(i), salt)};
      chk("mid_rst_word", rxq[0][i], e);
    end
    repeat (20) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("no_done_after_rst", ndone[k], 0);
      chk("idle_after_rst", {bsy[k], ov[k]}, 0);
    end
    sweep(15'h0300, 6, 0, 0);

    for (int r = 0; r < 10; r++) begin
      salt = $urandom;
      n = $urandom_range(0, 12);
      sweep(15'($urandom), n, $urandom_range(0, 2),
            n > 0 ? $urandom_range(2, 4) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
